// File: rtl/ahb_mem_bist_master.sv
// AHB-lite BIST master: fills or checks the SRAM slave with seed ^ byte-address,
// using pipelined SINGLE/INCR4/INCR8/INCR16 transfers.
module ahb_mem_bist_master #(
  parameter int mem_depth = 1024,
  parameter int mem_abit  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                wr_mode,
  input  logic [mem_abit+1:0] base_addr,
  input  logic [mem_abit:0]   word_num,
  input  logic [1:0]          burst_sel,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                resp_err,
  output logic [15:0]         err_cnt,
  output logic [mem_abit+1:0] err_addr,
  output logic                hsel,
  output logic [mem_abit+1:0] haddr,
  output logic [2:0]          hburst,
  output logic [1:0]          htrans,
  output logic [2:0]          hsize,
  output logic [3:0]          hprot,
  output logic                hwrite,
  output logic [31:0]         hwdata,
  output logic                hready,
  input  logic                hreadyout,
  input  logic [31:0]         hrdata,
  input  logic [1:0]          hresp
);
  localparam int AW = mem_abit + 2;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [mem_abit:0] ONE_W = 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BEAT, S_LAST, S_ERR} state_t;

  state_t            state;
  logic [1:0]        htrans_q;
  logic [31:0]       seed_q;
  logic [1:0]        bsel_q;
  logic [mem_abit:0] addr_left;   // addresses still to issue after the current one
  logic [4:0]        beat_left;   // beats left in the current burst after the current one
  logic              dp_valid;
  logic [AW-1:0]     dp_addr;

  logic              err_cyc1, cmp_hit, cmd_bad;
  logic [AW-1:0]     nxt_addr, cmd_end;
  logic [4:0]        first_len, next_len;

  // Burst length for a burst starting at word offset 'off' within its 1 KB page.
  function automatic logic [4:0] burst_beats(input logic [7:0] off,
                                             input logic [mem_abit:0] left,
                                             input logic [1:0] sel);
    logic [4:0] b;
    logic [8:0] end_off;
    case (sel)
      2'd1:    b = 5'd4;
      2'd2:    b = 5'd8;
      2'd3:    b = 5'd16;
      default: b = 5'd1;
    endcase
    end_off = {1'b0, off} + {4'b0, b};
    if (b != 5'd1 && left >= (mem_abit+1)'(b) && end_off <= 9'd256) return b;
    return 5'd1;
  endfunction

  function automatic logic [2:0] burst_code(input logic [4:0] b);
    case (b)
      5'd4:    return 3'b011;
      5'd8:    return 3'b101;
      5'd16:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // First ERROR cycle cancels the pending address combinationally.
  assign err_cyc1  = dp_valid && (hresp == 2'b01) && !hreadyout;
  assign htrans    = err_cyc1 ? T_IDLE : htrans_q;
  assign hsel      = htrans[1];
  assign hready    = hreadyout;
  assign hsize     = 3'b010;
  assign hprot     = 4'b0011;

  assign nxt_addr  = haddr + AW'(4);
  assign cmd_end   = AW'(base_addr[AW-1:2]) + AW'(word_num);
  assign cmd_bad   = (word_num == '0) || (base_addr[1:0] != 2'b00) || (cmd_end > AW'(mem_depth));
  assign first_len = burst_beats(base_addr[9:2], word_num, burst_sel);
  assign next_len  = burst_beats(nxt_addr[9:2], addr_left, bsel_q);
  assign cmp_hit   = dp_valid && hreadyout && !hwrite && (hrdata != (seed_q ^ 32'(dp_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      htrans_q  <= T_IDLE;
      haddr     <= '0;
      hburst    <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      resp_err  <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      seed_q    <= '0;
      bsel_q    <= '0;
      addr_left <= '0;
      beat_left <= '0;
      dp_valid  <= 1'b0;
      dp_addr   <= '0;
    end else begin
      done <= 1'b0;
      if (cmp_hit) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == '0) err_addr <= dp_addr;
      end
      case (state)
        S_IDLE: if (start) begin
          if (cmd_bad) begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
          end else begin
            cfg_err   <= 1'b0;
            resp_err  <= 1'b0;
            err_cnt   <= '0;
            err_addr  <= '0;
            seed_q    <= seed;
            bsel_q    <= burst_sel;
            hwrite    <= wr_mode;
            busy      <= 1'b1;
            haddr     <= base_addr;
            htrans_q  <= T_NONSEQ;
            hburst    <= burst_code(first_len);
            beat_left <= first_len - 5'd1;
            addr_left <= word_num - ONE_W;
            state     <= S_ADDR;
          end
        end
        S_ADDR, S_BEAT: if (err_cyc1) begin
          htrans_q <= T_IDLE;
          dp_valid <= 1'b0;
          state    <= S_ERR;
        end else if (hreadyout) begin
          dp_valid <= 1'b1;
          dp_addr  <= haddr;
          if (hwrite) hwdata <= seed_q ^ 32'(haddr);
          if (addr_left == '0) begin
            htrans_q <= T_IDLE;
            state    <= S_LAST;
          end else begin
            haddr     <= nxt_addr;
            addr_left <= addr_left - ONE_W;
            state     <= S_BEAT;
            if (beat_left != '0) begin
              htrans_q  <= T_SEQ;
              beat_left <= beat_left - 5'd1;
            end else begin
              htrans_q  <= T_NONSEQ;
              hburst    <= burst_code(next_len);
              beat_left <= next_len - 5'd1;
            end
          end
        end
        S_LAST: if (err_cyc1) begin
          dp_valid <= 1'b0;
          state    <= S_ERR;
        end else if (hreadyout) begin
          dp_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        S_ERR: begin
          resp_err <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_mem_bist_master.sv
// Directed bench for ahb_mem_bist_master with a behavioural SRAM slave that can
// inject wait states, ERROR responses and read-data corruption.
module tb_ahb_mem_bist_master;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, wr_mode = 1'b0;
  logic [11:0] base_addr = '0;
  logic [10:0] word_num = '0;
  logic [1:0]  burst_sel = '0;
  logic [31:0] seed = '0;
  logic        busy, done, cfg_err, resp_err, hsel, hwrite, hready, hreadyout;
  logic [15:0] err_cnt;
  logic [11:0] err_addr, haddr;
  logic [2:0]  hburst, hsize;
  logic [1:0]  htrans, hresp;
  logic [3:0]  hprot;
  logic [31:0] hwdata, hrdata;
  int n_vec = 0, n_bad = 0;

  ahb_mem_bist_master #(.mem_depth(1024), .mem_abit(10)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_mode(wr_mode), .base_addr(base_addr),
    .word_num(word_num), .burst_sel(burst_sel), .seed(seed), .busy(busy), .done(done),
    .cfg_err(cfg_err), .resp_err(resp_err), .err_cnt(err_cnt), .err_addr(err_addr),
    .hsel(hsel), .haddr(haddr), .hburst(hburst), .htrans(htrans), .hsize(hsize),
    .hprot(hprot), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp));

  always #5 clk = ~clk;

  // Slave model
  logic [31:0] mem [0:1023];
  logic        dp_act = 1'b0, dp_wr = 1'b0, corrupt_en = 1'b0;
  logic [11:0] dp_a = '0, corrupt_addr = '0;
  int dp_beat = 0, wcnt = 0, ecnt = 0, acc_cnt = 0, acc_total = 0;
  int stall_beat = 0, stall_len = 0, err_beat = 0;
  logic [11:0] log_addr  [0:31];
  logic [1:0]  log_trans [0:31];
  logic [2:0]  log_burst [0:31];
  logic        log_write [0:31];

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 2'b00;
    if (dp_act && dp_beat == stall_beat && wcnt < stall_len) hreadyout = 1'b0;
    else if (dp_act && dp_beat == err_beat) begin
      hresp     = 2'b01;
      hreadyout = (ecnt != 0);
    end
  end
  assign hrdata = mem[dp_a[11:2]] ^ ((corrupt_en && dp_a == corrupt_addr) ? 32'h0000_0100 : 32'h0);

  always @(posedge clk) begin
    if (rst) begin
      dp_act <= 1'b0; wcnt <= 0; ecnt <= 0; acc_cnt <= 0;
    end else begin
      if (!busy) acc_cnt <= 0;
      if (!hready) begin
        if (hresp[0]) ecnt <= ecnt + 1; else wcnt <= wcnt + 1;
      end else begin
        if (dp_act && dp_wr && !hresp[0]) mem[dp_a[11:2]] <= hwdata;
        wcnt <= 0; ecnt <= 0;
        dp_act <= hsel && htrans[1];
        if (hsel && htrans[1]) begin
          dp_a <= haddr; dp_wr <= hwrite; dp_beat <= acc_cnt + 1; acc_total <= acc_total + 1;
          if (acc_cnt < 32) begin
            log_addr[acc_cnt[4:0]] <= haddr;  log_trans[acc_cnt[4:0]] <= htrans;
            log_burst[acc_cnt[4:0]] <= hburst; log_write[acc_cnt[4:0]] <= hwrite;
          end
          if (busy) acc_cnt <= acc_cnt + 1;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [11:0] b, input logic [10:0] n,
                       input logic [1:0] s, input logic [31:0] sd);
    @(negedge clk);
    wr_mode = w; base_addr = b; word_num = n; burst_sel = s; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index (cycle after start = 1) at which done is seen, -1 on timeout.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({htrans, hsel, haddr, hburst, hwrite} !== '0) begin n_bad++;
      $display("FAIL reset_bus got %h exp 0", {htrans, hsel, haddr, hburst, hwrite}); end
    n_vec++; if (hwdata !== 32'h0) begin n_bad++; $display("FAIL reset_hwdata got %h exp 0", hwdata); end
    n_vec++; if ({busy, done, cfg_err, resp_err, err_cnt, err_addr} !== '0) begin n_bad++;
      $display("FAIL reset_status got %h exp 0", {busy, done, cfg_err, resp_err, err_cnt, err_addr}); end
    n_vec++; if ({hsize, hprot} !== 7'b010_0011) begin n_bad++;
      $display("FAIL reset_size_prot got %b exp 0100011", {hsize, hprot}); end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int c;
    issue(1'b1, 12'h000, 11'd8, 2'd1, 32'hA5A5_0000);
    n_vec++; if ({htrans, hsel, haddr, hburst, hwrite, busy} !== {2'b10, 1'b1, 12'h000, 3'b011, 1'b1, 1'b1}) begin n_bad++;
      $display("FAIL wr_first_addr got %h exp %h", {htrans, hsel, haddr, hburst, hwrite, busy},
               {2'b10, 1'b1, 12'h000, 3'b011, 1'b1, 1'b1}); end
    wait_done(1, c);
    n_vec++; if (c !== 10) begin n_bad++; $display("FAIL wr_done_cycle got %0d exp 10", c); end
    n_vec++; if ({log_trans[0], log_burst[0], log_trans[1], log_addr[1], log_trans[4], log_addr[4], log_trans[7], log_addr[7]}
                 !== {2'b10, 3'b011, 2'b11, 12'h004, 2'b10, 12'h010, 2'b11, 12'h01C}) begin n_bad++;
      $display("FAIL wr_burst_shape got a4=%h t4=%h a7=%h", log_addr[4], log_trans[4], log_addr[7]); end
    n_vec++; if (mem[1] !== 32'hA5A5_0004 || mem[7] !== 32'hA5A5_001C) begin n_bad++;
      $display("FAIL wr_mem_data got %h %h exp a5a50004 a5a5001c", mem[1], mem[7]); end
    issue(1'b0, 12'h000, 11'd8, 2'd1, 32'hA5A5_0000);
    @(negedge clk); @(negedge clk);
    wr_mode = 1'b1; base_addr = 12'h100; word_num = 11'd1; start = 1'b1;  // must be ignored
    @(negedge clk);
    start = 1'b0;
    wait_done(4, c);
    n_vec++; if (c !== 10) begin n_bad++; $display("FAIL rd_done_cycle got %0d exp 10", c); end
    n_vec++; if ({err_cnt, err_addr, log_write[0], log_write[7]} !== '0) begin n_bad++;
      $display("FAIL rd_clean got cnt=%h addr=%h", err_cnt, err_addr); end
    repeat (3) @(negedge clk);
    n_vec++; if ({busy, done, htrans} !== 4'b0) begin n_bad++;
      $display("FAIL rd_ignored_start got %b exp 0000", {busy, done, htrans}); end
  endtask

  task automatic test_boundary;
    int c;
    issue(1'b1, 12'h3F8, 11'd4, 2'd1, 32'h0F0F_1234);
    wait_done(1, c);
    n_vec++; if (c !== 6) begin n_bad++; $display("FAIL bnd_done_cycle got %0d exp 6", c); end
    n_vec++; if ({log_trans[0], log_trans[1], log_trans[2], log_trans[3]} !== 8'hAA ||
                 {log_burst[0], log_burst[1], log_burst[2], log_burst[3]} !== 12'h0) begin n_bad++;
      $display("FAIL bnd_singles got t=%h%h%h%h b=%h%h%h%h", log_trans[0], log_trans[1], log_trans[2],
               log_trans[3], log_burst[0], log_burst[1], log_burst[2], log_burst[3]); end
    n_vec++; if ({log_addr[0], log_addr[2], log_addr[3]} !== {12'h3F8, 12'h400, 12'h404}) begin n_bad++;
      $display("FAIL bnd_addrs got %h %h %h", log_addr[0], log_addr[2], log_addr[3]); end
    issue(1'b0, 12'h3F8, 11'd4, 2'd1, 32'h0F0F_1234);
    wait_done(1, c);
    n_vec++; if (c !== 6 || err_cnt !== 16'd0) begin n_bad++;
      $display("FAIL bnd_read got cyc=%0d cnt=%0d exp 6 0", c, err_cnt); end
  endtask

  task automatic test_cfg_err;
    int t;
    t = acc_total;
    issue(1'b0, 12'hFFC, 11'd2, 2'd1, 32'h0);
    n_vec++; if ({cfg_err, done, busy, htrans} !== 5'b11000) begin n_bad++;
      $display("FAIL cfg_range got %b exp 11000", {cfg_err, done, busy, htrans}); end
    repeat (3) @(negedge clk);
    n_vec++; if (done !== 1'b0 || htrans !== 2'b00 || acc_total !== t) begin n_bad++;
      $display("FAIL cfg_no_bus got done=%b htrans=%h xfers=%0d", done, htrans, acc_total - t); end
    issue(1'b1, 12'h000, 11'd0, 2'd0, 32'h0);
    n_vec++; if ({cfg_err, done, busy} !== 3'b110) begin n_bad++;
      $display("FAIL cfg_zero got %b exp 110", {cfg_err, done, busy}); end
  endtask

  task automatic test_corrupt;
    int c;
    issue(1'b1, 12'h000, 11'd16, 2'd3, 32'h1234_5678);
    wait_done(1, c);
    n_vec++; if (c !== 18 || cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL cor_write got cyc=%0d cfg_err=%b exp 18 0", c, cfg_err); end
    corrupt_addr = 12'h028; corrupt_en = 1'b1;
    issue(1'b0, 12'h000, 11'd16, 2'd3, 32'h1234_5678);
    wait_done(1, c);
    n_vec++; if (c !== 18 || err_cnt !== 16'd1 || err_addr !== 12'h028) begin n_bad++;
      $display("FAIL cor_detect got cyc=%0d cnt=%0d addr=%h exp 18 1 028", c, err_cnt, err_addr); end
    n_vec++; if ({log_burst[0], log_trans[0], log_trans[15], log_addr[15]} !== {3'b111, 2'b10, 2'b11, 12'h03C}) begin n_bad++;
      $display("FAIL cor_incr16 got b=%h t15=%h a15=%h", log_burst[0], log_trans[15], log_addr[15]); end
    repeat (3) @(negedge clk);
    n_vec++; if (err_cnt !== 16'd1 || err_addr !== 12'h028) begin n_bad++;
      $display("FAIL cor_stable got cnt=%0d addr=%h", err_cnt, err_addr); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_wait_err;
    int c, t;
    stall_beat = 3; stall_len = 2; err_beat = 6;
    t = acc_total;
    issue(1'b1, 12'h200, 11'd8, 2'd2, 32'hC0DE_0000);
    repeat (3) @(negedge clk);
    n_vec++; if ({hreadyout, haddr, htrans, hburst, hwdata} !== {1'b0, 12'h20C, 2'b11, 3'b101, 32'hC0DE_0208}) begin n_bad++;
      $display("FAIL ws_stall1 got rdy=%b a=%h t=%h d=%h", hreadyout, haddr, htrans, hwdata); end
    @(negedge clk);
    n_vec++; if ({hreadyout, haddr, htrans, hburst, hwdata} !== {1'b0, 12'h20C, 2'b11, 3'b101, 32'hC0DE_0208}) begin n_bad++;
      $display("FAIL ws_stall2 got rdy=%b a=%h t=%h d=%h", hreadyout, haddr, htrans, hwdata); end
    repeat (4) @(negedge clk);
    n_vec++; if ({hresp, hreadyout, htrans, hsel} !== {2'b01, 1'b0, 2'b00, 1'b0}) begin n_bad++;
      $display("FAIL err_cycle1 got resp=%h rdy=%b t=%h sel=%b", hresp, hreadyout, htrans, hsel); end
    wait_done(9, c);
    n_vec++; if (c !== 11 || resp_err !== 1'b1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL err_done got cyc=%0d resp_err=%b busy=%b exp 11 1 0", c, resp_err, busy); end
    repeat (3) @(negedge clk);
    n_vec++; if (acc_total - t !== 6 || htrans !== 2'b00) begin n_bad++;
      $display("FAIL err_no_more got xfers=%0d htrans=%h exp 6 0", acc_total - t, htrans); end
    stall_beat = 0; stall_len = 0; err_beat = 0;
  endtask

  task automatic test_reset_mid;
    int c, nd;
    issue(1'b0, 12'h000, 11'd16, 2'd3, 32'h1234_5678);
    @(negedge clk);
    n_vec++; if (resp_err !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL rm_accept got resp_err=%b busy=%b exp 0 1", resp_err, busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({htrans, hsel, busy} !== 4'b0) begin n_bad++;
      $display("FAIL rm_abort got %b exp 0000", {htrans, hsel, busy}); end
    rst = 1'b0;
    nd = 0;
    repeat (20) begin @(negedge clk); if (done === 1'b1) nd++; end
    n_vec++; if (nd !== 0) begin n_bad++; $display("FAIL rm_no_done got %0d exp 0", nd); end
    issue(1'b0, 12'h000, 11'd16, 2'd3, 32'h1234_5678);
    wait_done(1, c);
    n_vec++; if (c !== 18 || err_cnt !== 16'd0) begin n_bad++;
      $display("FAIL rm_rerun got cyc=%0d cnt=%0d exp 18 0", c, err_cnt); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_boundary;
    test_cfg_err;
    test_corrupt;
    test_wait_err;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_mem_bist_master.md
# ahb_mem_bist_master

AHB-lite master that fills and checks the on-chip SRAM slave (`ahb_sram`) with an address-derived pattern. It sits directly upstream of `ahb_sram` on the single-slave AHB-lite segment, in the place the bench master model occupies. It issues pipelined 32-bit SINGLE/INCR4/INCR8/INCR16 transfers, honours slave wait states and ERROR responses, and on reads reports the mismatch count and the first failing address.

## Interface
- `mem_depth`, 1024, SRAM depth in 32-bit words
- `mem_abit`, 10, word address bits; byte address width is `mem_abit+2`
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle command pulse; accepted only while `busy`=0
- `wr_mode` in 1: 1 = write pattern, 0 = read and check
- `base_addr` in `mem_abit+2`: start byte address; bits [1:0] must be 0
- `word_num` in `mem_abit+1`: number of words, 1..`mem_depth`
- `burst_sel` in 2: 0 SINGLE, 1 INCR4, 2 INCR8, 3 INCR16
- `seed` in 32: pattern seed
- `busy` out 1: command in progress
- `done` out 1: one-cycle completion pulse
- `cfg_err` out 1: last command rejected
- `resp_err` out 1: last command aborted on hresp ERROR
- `err_cnt` out 16: read mismatches, saturating at 0xFFFF
- `err_addr` out `mem_abit+2`: byte address of the first mismatch
- `hsel` out 1, `haddr` out `mem_abit+2`, `hburst` out 3, `htrans` out 2, `hsize` out 3, `hprot` out 4, `hwrite` out 1, `hwdata` out 32: AHB-lite master outputs
- `hready` out 1: equals `hreadyout`; this block drives the segment's hready
- `hreadyout` in 1, `hrdata` in 32, `hresp` in 2: slave response

## Operation
- Pattern word for byte address A: `seed ^ {zero-extended A}`.
- `hsize`=3'b010 always. `hprot`=4'b0011 always. `hsel`=1 while an address phase is NONSEQ/SEQ, otherwise 0.
- Command check on `start`: reject if `word_num`=0, `base_addr[1:0]`≠0, or `base_addr/4 + word_num > mem_depth`. On reject: `cfg_err`=1, `done` pulses next cycle, no bus activity.
- On accept: clear `cfg_err`, `resp_err`, `err_cnt`, and `err_addr` (to 0). Latch the command and assert `busy`.
- Burst choice per burst: beats B from `burst_sel`. Issue INCR-B only if remaining ≥ B and the burst does not cross a 1 KB boundary. Otherwise issue one SINGLE and re-evaluate at the next word.
- FSM states:
  - IDLE: wait for `start`.
  - ADDR: first address phase of a burst, htrans NONSEQ.
  - BEAT: pipelined; htrans SEQ for next beat, or the next burst's NONSEQ, or IDLE after the last address.
  - LAST: final data phase only.
  - ERR: second ERROR cycle.
  - Transitions: IDLE→ADDR on accepted start; ADDR→BEAT; BEAT→LAST once every address has been issued; LAST→IDLE with `done` when the final data phase completes with hreadyout=1.
- Bursts are back-to-back with no idle cycle between them. BUSY htrans is never issued.
- Write: `hwdata` carries the pattern for the address of the current data phase and is held through wait states.
- Read: when a data phase completes (hreadyout=1), compare `hrdata` with the pattern. On mismatch, increment `err_cnt`; on the first mismatch of the command, also capture `err_addr`.
- ERROR response (hresp=1):
  - Cycle 1 (hreadyout=0): drive htrans=IDLE and cancel the pending address.
  - Next cycle → ERR; set `resp_err`, pulse `done`, return to IDLE.
  - A data phase that ends in ERROR is not compared.

## Timing
- Reset (sync, `rst`=1 at a clk edge) values:
  - `htrans`=0, `hsel`=0, `haddr`=0, `hburst`=0, `hwrite`=0, `hwdata`=0.
  - `busy`=0, `done`=0, `cfg_err`=0, `resp_err`=0, `err_cnt`=0, `err_addr`=0; FSM in IDLE.
  - Reset mid-command abandons it immediately: htrans=IDLE the cycle after, and no `done` pulse.
- Address and control for the first transfer appear on the cycle after the accepted `start`.
- All address/control/hwdata outputs are held stable while hreadyout=0.
- With zero wait states, N words take N+1 bus cycles; `done` is asserted in the cycle after the last data phase completes.
- `start` while `busy`=1 is ignored.
- `err_cnt` and `err_addr` are stable from the `done` pulse until the next accepted start.

## Test plan
- Write `base_addr`=0x000, `word_num`=8, INCR4, `seed`=0xA5A50000, then read back with the same settings → two INCR4 bursts each time, `err_cnt`=0, read `done` 10 cycles after start.
- INCR4 with `base_addr`=0x3F8, `word_num`=4 → SINGLE, SINGLE (no crossing of 0x400), then INCR4 at 0x400 is not issued since remaining=2 → SINGLE, SINGLE; all data match.
- Write 16 words, backdoor-corrupt word 0x028, read INCR16 → `err_cnt`=1, `err_addr`=0x028.
- `base_addr`=0xFFC, `word_num`=2 → `cfg_err`=1, `done` pulse, `htrans` stays 0.
- Forced 2-cycle wait state on beat 3 of INCR8, then hresp ERROR on beat 6 → outputs held during the stall; htrans=IDLE on ERROR cycle 1; `resp_err`=1; no further transfers.
- `rst` asserted mid-INCR16 → next cycle `htrans`=0, `busy`=0; a new command then completes normally.
